// File: rtl/dram_preload_ctrl.sv
// Boot sequencer for the harness DRAM: loads the ELF image, releases the core,
// arbitrates the single SRAM port and latches the tohost exit status.
module dram_preload_ctrl #(
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          DataWidth    = 128,
  parameter logic [AddrWidth-1:0] DRAMAddrBase = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] DRAMLength   = 64'h4000_0000,
  localparam int unsigned         BeWidth      = DataWidth / 8,
  localparam int unsigned         ByteOff      = $clog2(BeWidth),
  localparam int unsigned         MemAw        = $clog2(DRAMLength / BeWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [AddrWidth-1:0] pl_addr_i,
  input  logic [DataWidth-1:0] pl_data_i,
  input  logic                 pl_last_i,
  input  logic                 pl_skip_i,
  input  logic                 soc_req_i,
  output logic                 soc_gnt_o,
  input  logic                 soc_we_i,
  input  logic [AddrWidth-1:0] soc_addr_i,
  input  logic [DataWidth-1:0] soc_wdata_i,
  input  logic [BeWidth-1:0]   soc_be_i,
  output logic                 soc_rvalid_o,
  output logic [DataWidth-1:0] soc_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [MemAw-1:0]     mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]   mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic [63:0]          exit_i,
  output logic                 core_en_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [62:0]          exit_code_o,
  output logic [31:0]          beat_cnt_o,
  output logic [15:0]          err_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   beat_q, beat_d;
  logic [15:0]   err_q, err_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [62:0]   code_q, code_d;
  logic          rvalid_q, rvalid_d;
  logic          rd_ok_q, rd_ok_d;
  logic [AddrWidth-1:0] sel_addr;
  logic          sel_legal;

  function automatic logic addr_legal(input logic [AddrWidth-1:0] a);
    return (a >= DRAMAddrBase) && (a < DRAMAddrBase + DRAMLength) &&
           (a[ByteOff-1:0] == '0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

  // Only one requester can own the SRAM in any state, so one address path serves both.
  assign sel_addr   = (state_q == S_LOAD) ? pl_addr_i : soc_addr_i;
  assign sel_legal  = addr_legal(sel_addr);
  assign mem_addr_o = MemAw'((sel_addr - DRAMAddrBase) >> ByteOff);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    err_d       = err_q;
    done_d      = done_q;
    fail_d      = fail_q;
    code_d      = code_q;
    rvalid_d    = 1'b0;
    rd_ok_d     = 1'b0;
    pl_ready_o  = 1'b0;
    soc_gnt_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    unique case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        pl_ready_o = 1'b1;
        if (pl_valid_i) begin
          if (sel_legal) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_wdata_o = pl_data_i;
            mem_be_o    = '1;
            beat_d      = sat_inc(beat_q, 32'hFFFF_FFFF);
          end else begin
            err_d = 16'(sat_inc({16'h0, err_q}, 32'h0000_FFFF));
          end
        end
        if ((pl_valid_i && pl_last_i) || pl_skip_i) state_d = S_RUN;
      end
      S_RUN, S_DONE: begin
        soc_gnt_o = soc_req_i;
        if (soc_req_i) begin
          rvalid_d = !soc_we_i;
          if (sel_legal) begin
            mem_req_o   = 1'b1;
            mem_we_o    = soc_we_i;
            mem_wdata_o = soc_wdata_i;
            mem_be_o    = soc_be_i;
            rd_ok_d     = !soc_we_i;
          end else begin
            err_d = 16'(sat_inc({16'h0, err_q}, 32'h0000_FFFF));
          end
        end
        // The exit word is captured once; DONE never re-samples it.
        if (state_q == S_RUN && exit_i[0]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = |exit_i[63:1];
          code_d  = exit_i[63:1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= '0;
      rvalid_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      rvalid_q <= rvalid_d;
      rd_ok_q  <= rd_ok_d;
    end
  end

  // SRAM data arrives one cycle after the request, alongside rvalid.
  assign soc_rvalid_o = rvalid_q;
  assign soc_rdata_o  = rd_ok_q ? mem_rdata_i : '0;
  assign core_en_o    = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign exit_code_o  = code_q;
  assign beat_cnt_o   = beat_q;
  assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_dram_preload_ctrl.sv
// Directed bench for dram_preload_ctrl with a small behavioural SRAM on the memory port.
module tb_dram_preload_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         pl_valid, pl_ready, pl_last, pl_skip;
  logic [63:0]  pl_addr;
  logic [127:0] pl_data;
  logic         soc_req, soc_gnt, soc_we, soc_rvalid;
  logic [63:0]  soc_addr;
  logic [127:0] soc_wdata, soc_rdata;
  logic [15:0]  soc_be;
  logic         mem_req, mem_we;
  logic [25:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  mem_be;
  logic [63:0]  exit_w;
  logic         core_en, done, fail;
  logic [62:0]  exit_code;
  logic [31:0]  beat_cnt;
  logic [15:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  logic [127:0] sram [0:15];
  logic [127:0] rows [0:2];

  always #5 clk = ~clk;

  dram_preload_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_addr_i(pl_addr),
    .pl_data_i(pl_data), .pl_last_i(pl_last), .pl_skip_i(pl_skip),
    .soc_req_i(soc_req), .soc_gnt_o(soc_gnt), .soc_we_i(soc_we),
    .soc_addr_i(soc_addr), .soc_wdata_i(soc_wdata), .soc_be_i(soc_be),
    .soc_rvalid_o(soc_rvalid), .soc_rdata_o(soc_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .exit_i(exit_w), .core_en_o(core_en), .done_o(done), .fail_o(fail),
    .exit_code_o(exit_code), .beat_cnt_o(beat_cnt), .err_cnt_o(err_cnt)
  );

  // Harness SRAM: 16 rows, byte-masked write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 16; b++)
          if (mem_be[b]) sram[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[3:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bad [0:2];
    bad[0] = 64'h7FFF_FFF0; bad[1] = 64'hC000_0000; bad[2] = 64'h8000_0008;
    rows[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    rows[1] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    rows[2] = 128'hA5A5_5A5A_FFFF_0000_1234_5678_9ABC_DEF0;
    for (int r = 0; r < 16; r++) sram[r] = '0;
    mem_rdata = '0;
    rst = 1'b1; pl_valid = 0; pl_addr = '0; pl_data = '0; pl_last = 0; pl_skip = 0;
    soc_req = 1'b1; soc_we = 0; soc_addr = 64'h8000_0000; soc_wdata = '0; soc_be = '1;
    exit_w = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_pl_ready", pl_ready, 0);
    check("rst_gnt", soc_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_core_en", core_en, 0);
    check("rst_status", {done, fail, soc_rvalid}, 0);
    check("rst_cnts", {beat_cnt, err_cnt, exit_code}, 0);
    check("rst_rdata", soc_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("load_ready", pl_ready, 1);

    // SoC request and exit pulse while loading must be ignored
    exit_w = 64'h55;
    #1;
    check("load_gnt", soc_gnt, 0);
    step();
    check("load_exit_ign", done, 0);
    soc_req = 0; exit_w = '0;

    for (int i = 0; i < 3; i++) begin
      pl_valid = 1; pl_addr = bad[i]; pl_data = rows[0];
      #1;
      check($sformatf("bad_beat%0d_req", i), mem_req, 0);
      step();
    end
    pl_valid = 0;
    check("bad_err_cnt", err_cnt, 3);
    check("bad_beat_cnt", beat_cnt, 0);

    for (int i = 0; i < 3; i++) begin
      pl_valid = 1; pl_addr = 64'h8000_0000 + 64'(16 * i); pl_data = rows[i];
      pl_last = (i == 2);
      #1;
      check($sformatf("beat%0d_wr", i), {mem_req, mem_we, mem_be}, {2'b11, 16'hFFFF});
      check($sformatf("beat%0d_addr", i), mem_addr, i);
      check($sformatf("beat%0d_data", i), mem_wdata, rows[i]);
      check($sformatf("beat%0d_core_en", i), core_en, 0);
      step();
    end
    pl_valid = 0; pl_last = 0;
    check("run_core_en", core_en, 1);
    check("run_pl_ready", pl_ready, 0);
    check("run_beat_cnt", beat_cnt, 3);

    soc_req = 1; soc_we = 0; soc_addr = 64'h8000_0010;
    #1;
    check("rd1_gnt", soc_gnt, 1);
    check("rd1_mem", {mem_req, mem_we, mem_addr}, {2'b10, 26'd1});
    step();
    check("rd1_rvalid", soc_rvalid, 1);
    check("rd1_data", soc_rdata, rows[1]);
    soc_addr = 64'h8000_0020;
    step();
    check("rd2_data", {soc_rvalid, soc_rdata}, {1'b1, rows[2]});
    soc_addr = 64'h8000_0000;
    step();
    check("rd0_data", {soc_rvalid, soc_rdata}, {1'b1, rows[0]});
    soc_addr = 64'hC000_0000;
    #1;
    check("oor_gnt_req", {soc_gnt, mem_req}, 2'b10);
    step();
    check("oor_rdata", {soc_rvalid, soc_rdata}, {1'b1, 128'h0});
    check("oor_err_cnt", err_cnt, 4);
    soc_req = 0;
    step();
    check("rvalid_drop", soc_rvalid, 0);

    exit_w = 64'h55;
    step();
    check("exit55", {done, fail, exit_code}, {2'b11, 63'h2A});
    exit_w = 64'h3;
    step();
    check("exit_sticky", {done, fail, exit_code}, {2'b11, 63'h2A});
    exit_w = '0;

    restart();
    pl_skip = 1;
    step();
    pl_skip = 0;
    check("skip_run", {core_en, beat_cnt}, {1'b1, 32'd0});
    exit_w = 64'h1;
    step();
    check("exit1", {done, fail, exit_code}, {2'b10, 63'h0});
    exit_w = '0;

    restart();
    pl_valid = 1; pl_addr = 64'h8000_0030; pl_data = rows[2];
    step();
    pl_valid = 0;
    check("midload_beat", beat_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("midload_rst", {pl_ready, core_en, beat_cnt, err_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    pl_valid = 1; pl_addr = 64'h0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("err_sat", err_cnt, 16'hFFFF);
    check("sat_no_beat", {mem_req, beat_cnt}, 0);
    pl_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
